dff_pipe_array: RTL and testbench



---
 rtl/dff_pipe_array_pkg.sv | 25 ++
 rtl/dff_en_r.sv | 22 ++
 rtl/dff_pipe_array.sv | 104 ++++++++++
 tb/tb_dff_pipe_array.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/dff_pipe_array_pkg.sv
// Shared sizing helpers for pipeline blocks, so sibling blocks derive their
// tap-index and occupancy-count widths the same way.
package dff_pipe_array_pkg;

   // Ceiling log2 that can be evaluated at elaboration time; clog2(1) = 0.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(v)) r = i + 1;
      end
      return r;
   endfunction

   // Stage-index width; at least one bit, even when DEPTH = 1.
   function automatic int unsigned tap_w(input int unsigned depth);
      return (depth > 1) ? clog2(depth) : 1;
   endfunction

   // Width of a count that ranges over 0..depth.
   function automatic int unsigned cnt_w(input int unsigned depth);
      return clog2(depth + 1);
   endfunction

endpackage

// File: rtl/dff_en_r.sv
// WIDTH-bit register with load enable and asynchronous active-high reset.
//   clk : rising-edge clock
//   rst : asynchronous reset, loads RESET_VAL
//   en  : load d at the edge when 1
//   d/q : data in / registered data out
module dff_en_r #(
   parameter int unsigned           WIDTH     = 8,
   parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)     q <= RESET_VAL;
      else if (en) q <= d;
   end

endmodule

// File: rtl/dff_pipe_array.sv
// WIDTH-lane, DEPTH-stage registered delay line with per-stage valid bits,
// stall enable, valid-only flush, registered occupancy and a tap read port.
//   clk, rst          : clock, asynchronous active-high reset
//   en                : advance the line; 0 holds every stage
//   flush             : clear all valid bits at the next edge (data untouched)
//   in_valid, d       : stage-0 input
//   q, out_valid      : last stage data and valid (no extra output register)
//   tap_sel           : stage index for the tap read
//   tap_q, tap_valid  : data/valid of stage tap_sel (combinational)
//   occupancy         : number of valid stages (registered)
module dff_pipe_array
   import dff_pipe_array_pkg::*;
#(
   parameter int unsigned      WIDTH     = 8,
   parameter int unsigned      DEPTH     = 4,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   localparam int unsigned     TAP_W     = tap_w(DEPTH),
   localparam int unsigned     CNT_W     = cnt_w(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             flush,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic             out_valid,
   input  logic [TAP_W-1:0] tap_sel,
   output logic [WIDTH-1:0] tap_q,
   output logic             tap_valid,
   output logic [CNT_W-1:0] occupancy
);

   logic [WIDTH-1:0] stage_q [DEPTH];
   logic [DEPTH-1:0] valid_q, valid_d;
   logic [CNT_W-1:0] occ_q, occ_d;
   logic             adv_c;

   // Data only moves on an enabled, non-flush edge.
   assign adv_c = en & ~flush;

   // Data stages; bubbles shift along with their data.
   for (genvar k = 0; k < DEPTH; k++) begin : stage
      logic [WIDTH-1:0] stage_in;
      if (k == 0) begin : g_head
         assign stage_in = d;
      end else begin : g_body
         assign stage_in = stage_q[k-1];
      end
      dff_en_r #(
         .WIDTH     (WIDTH),
         .RESET_VAL (RESET_VAL)
      ) u_reg (
         .clk (clk),
         .rst (rst),
         .en  (adv_c),
         .d   (stage_in),
         .q   (stage_q[k])
      );
   end

   // Valid shift and incremental occupancy; flush wins over advance.
   always_comb begin
      valid_d = valid_q;
      occ_d   = occ_q;
      if (flush) begin
         valid_d = '0;
         occ_d   = '0;
      end else if (en) begin
         valid_d[0] = in_valid;
         for (int k = 1; k < DEPTH; k++) valid_d[k] = valid_q[k-1];
         // One bit of headroom so the add/subtract never wraps mid-way.
         occ_d = CNT_W'({1'b0, occ_q} + (CNT_W+1)'(in_valid)
                        - (CNT_W+1)'(valid_q[DEPTH-1]));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
         occ_q   <= '0;
      end else begin
         valid_q <= valid_d;
         occ_q   <= occ_d;
      end
   end

   // Tap read; indices past the last stage return the reset value, invalid.
   always_comb begin
      tap_q     = RESET_VAL;
      tap_valid = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
         if (tap_sel == TAP_W'(k)) begin
            tap_q     = stage_q[k];
            tap_valid = valid_q[k];
         end
      end
   end

   assign q         = stage_q[DEPTH-1];
   assign out_valid = valid_q[DEPTH-1];
   assign occupancy = occ_q;

endmodule

// File: tb/tb_dff_pipe_array.sv
// Scoreboard bench for dff_pipe_array: the driver queues every accepted valid
// word, and a monitor pops and compares each word as it emerges on q.
module tb_dff_pipe_array;

   logic       clk = 1'b0;
   logic       clk_run = 1'b0;
   logic       rst, en, flush, in_valid;
   logic [7:0] d;
   logic [1:0] tap_sel, tap_sel3;
   logic [7:0] q, tap_q, q3, tap_q3;
   logic       out_valid, tap_valid, out_valid3, tap_valid3;
   logic [2:0] occupancy;
   logic [1:0] occupancy3;

   int errors = 0;
   int checks = 0;
   logic [7:0] exp_q [$];

   always #5 if (clk_run) clk = ~clk;

   dff_pipe_array #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h00)) u_dut (
      .clk(clk), .rst(rst), .en(en), .flush(flush), .in_valid(in_valid),
      .d(d), .q(q), .out_valid(out_valid), .tap_sel(tap_sel),
      .tap_q(tap_q), .tap_valid(tap_valid), .occupancy(occupancy)
   );

   dff_pipe_array #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'h5A)) u_dut3 (
      .clk(clk), .rst(rst), .en(en), .flush(flush), .in_valid(in_valid),
      .d(d), .q(q3), .out_valid(out_valid3), .tap_sel(tap_sel3),
      .tap_q(tap_q3), .tap_valid(tap_valid3), .occupancy(occupancy3)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Called at a negedge: drive inputs, then run one full clock.
   task automatic step(input logic e, input logic f, input logic iv, input logic [7:0] dv);
      en = e; flush = f; in_valid = iv; d = dv;
      if (f) exp_q.delete();
      else if (e && iv) exp_q.push_back(dv);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic tap_chk(input logic [1:0] sel, input logic [7:0] eq, input logic ev);
      tap_sel = sel;
      #1;
      chk($sformatf("tap%0d_q", sel), 32'(tap_q), 32'(eq));
      chk($sformatf("tap%0d_valid", sel), 32'(tap_valid), 32'(ev));
   endtask

   // Monitor: after each advancing edge, a valid output must match the queue head.
   initial begin
      logic adv;
      forever begin
         @(posedge clk);
         adv = en && !flush && !rst;
         @(negedge clk);
         if (adv && out_valid) begin
            if (exp_q.size() == 0) begin
               chk("sb_unexpected_out", 32'(q), 32'hFFFF_FFFF);
            end else begin
               chk("sb_q", 32'(q), 32'(exp_q.pop_front()));
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [2:0] occ_exp [8];
      logic [1:0] ov_exp  [8];
      int vcount;
      occ_exp = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2};
      ov_exp  = '{2'd2, 2'd2, 2'd2, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1}; // 2 = don't check

      rst = 1'b0; en = 1'b0; flush = 1'b0; in_valid = 1'b0; d = 8'h00;
      tap_sel = 2'd0; tap_sel3 = 2'd0;

      // 1: reset with clock held low acts without an edge
      #3 rst = 1'b1;
      #1;
      chk("rst_q", 32'(q), 32'h00);
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_occupancy", 32'(occupancy), 32'h0);
      clk_run = 1'b1;
      @(negedge clk);
      rst = 1'b0;

      // 2: fill
      step(1, 0, 1, 8'hAA);
      step(1, 0, 1, 8'hCC);
      step(1, 0, 1, 8'h0F);
      step(1, 0, 1, 8'hF0);
      chk("fill_q", 32'(q), 32'hAA);
      chk("fill_out_valid", 32'(out_valid), 32'h1);
      chk("fill_occupancy", 32'(occupancy), 32'd4);
      tap_chk(2'd0, 8'hF0, 1'b1);
      tap_chk(2'd3, 8'hAA, 1'b1);

      // 3: stall ignores d
      step(0, 0, 1, 8'h11);
      step(0, 0, 1, 8'h22);
      step(0, 0, 1, 8'h33);
      chk("hold_q", 32'(q), 32'hAA);
      chk("hold_occupancy", 32'(occupancy), 32'd4);
      tap_chk(2'd0, 8'hF0, 1'b1);
      tap_chk(2'd1, 8'h0F, 1'b1);
      tap_chk(2'd2, 8'hCC, 1'b1);
      tap_chk(2'd3, 8'hAA, 1'b1);
      step(1, 0, 0, 8'h00);
      chk("resume_q", 32'(q), 32'hCC);
      chk("resume_occupancy", 32'(occupancy), 32'd3);

      // 4: flush clears valids, keeps data, drops the input
      step(1, 1, 1, 8'h55);
      chk("flush_occupancy", 32'(occupancy), 32'd0);
      chk("flush_out_valid", 32'(out_valid), 32'h0);
      chk("flush_q_kept", 32'(q), 32'hCC);
      for (int i = 0; i < 4; i++) tap_chk(2'(i), (i == 0) ? 8'h00 : (i == 1) ? 8'hF0 :
                                          (i == 2) ? 8'h0F : 8'hCC, 1'b0);
      for (int i = 0; i < 4; i++) begin
         step(1, 0, 0, 8'h00);
         checks++;
         if (q === 8'h55) begin
            errors++;
            $display("FAIL flushed_word_seen: got %h expected not 55 at %0t", q, $time);
         end
         chk("post_flush_occupancy", 32'(occupancy), 32'd0);
      end

      // 5: alternating valid
      for (int i = 0; i < 8; i++) begin
         step(1, 0, ((i % 2) == 0), 8'(i + 1));
         chk($sformatf("alt_occ_%0d", i), 32'(occupancy), 32'(occ_exp[i]));
         if (ov_exp[i] != 2'd2)
            chk($sformatf("alt_out_valid_%0d", i), 32'(out_valid), 32'(ov_exp[i][0]));
      end
      vcount = 0;
      for (int i = 0; i < 4; i++) begin
         tap_sel = 2'(i);
         #1;
         if (tap_valid === 1'b1) vcount++;
      end
      chk("occ_eq_popcount", 32'(occupancy), 32'(vcount));

      // 6: bring occupancy to 3, then async reset mid-stream
      step(1, 0, 1, 8'h09);
      step(1, 0, 1, 8'h0A);
      chk("pre_rst_occupancy", 32'(occupancy), 32'd3);
      chk("pre_rst_q", 32'(q), 32'h07);
      tap_sel3 = 2'd0;
      #1;
      chk("d3_tap0_q", 32'(tap_q3), 32'h0A);
      chk("d3_tap0_valid", 32'(tap_valid3), 32'h1);
      tap_sel3 = 2'd3;
      #1;
      chk("d3_tap3_q", 32'(tap_q3), 32'h5A);
      chk("d3_tap3_valid", 32'(tap_valid3), 32'h0);
      en = 1'b0; in_valid = 1'b0;
      @(posedge clk);
      #2;
      exp_q.delete();
      rst = 1'b1;
      #1;
      chk("midrst_q", 32'(q), 32'h00);
      chk("midrst_out_valid", 32'(out_valid), 32'h0);
      chk("midrst_occupancy", 32'(occupancy), 32'h0);
      chk("midrst_d3_q", 32'(q3), 32'h5A);
      chk("midrst_d3_occupancy", 32'(occupancy3), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
